// File: rtl/game_sequencer.sv
// Reaction-game sequencer: shows pseudo-random LED patterns, scores matching
// key presses within a tick window, and reports a pass/fail verdict.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset; score/pattern view, waiting for start
// RELEASE | pattern blanked; waiting for all keys released
// SHOW    | pattern displayed; waiting for hit, wrong key or timeout
// RESULT  | game over; verdict view, score frozen, start replays
module game_sequencer #(
   parameter int ROUNDS     = 16,
   parameter int WINDOW     = 8,
   parameter int PASS_SCORE = 10,
   parameter int POINTS     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       tick,
   input  logic [3:0] key,
   output logic [7:0] score,
   output logic [3:0] pattern,
   output logic       C,
   output logic       res,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHOW    = 2'd1,
      RELEASE = 2'd2,
      RESULT  = 2'd3
   } state_t;

   // Window timer counts down from WINDOW-1; a tick at zero is the timeout.
   localparam int         WIN_M1      = WINDOW - 1;
   localparam logic [7:0] WIN_LAST    = WIN_M1[7:0];
   localparam int         ROUND_M1    = ROUNDS - 1;
   localparam logic [7:0] ROUND_LAST  = ROUND_M1[7:0];
   // Clamp so the 9-bit add/compare below stays exact for any parameter value.
   localparam int         PTS_CLAMP   = (POINTS > 255) ? 255 : POINTS;
   localparam logic [8:0] PTS9        = PTS_CLAMP[8:0];
   localparam int         PASS_CLAMP  = (PASS_SCORE > 256) ? 256 : PASS_SCORE;
   localparam logic [8:0] PASS9       = PASS_CLAMP[8:0];

   state_t     state_q, state_d;
   logic [7:0] score_q, score_d;
   logic [3:0] pattern_q, pattern_d;
   logic [7:0] round_q, round_d;
   logic [7:0] win_q, win_d;
   logic [3:0] lfsr_q, lfsr_d;
   logic       c_q, c_d;
   logic       res_q, res_d;
   logic       busy_q, busy_d;

   logic       hit;
   logic       miss;
   logic [8:0] score_sum;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d   = state_q;
      score_d   = score_q;
      pattern_d = pattern_q;
      round_d   = round_q;
      win_d     = win_q;
      lfsr_d    = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
      hit       = 1'b0;
      miss      = 1'b0;
      score_sum = {1'b0, score_q} + PTS9;

      case (state_q)
         IDLE, RESULT: begin
            pattern_d = 4'd0;
            if (start) begin
               score_d = 8'd0;
               round_d = 8'd0;
               win_d   = WIN_LAST;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            pattern_d = 4'd0;
            if (key == 4'd0) begin
               pattern_d = lfsr_q;
               win_d     = WIN_LAST;
               state_d   = SHOW;
            end
         end
         SHOW: begin
            // pattern_q is never zero here, so a hit implies a pressed key.
            hit  = (key == pattern_q);
            miss = ((key != 4'd0) && !hit) || (tick && (win_q == 8'd0));
            if (hit) begin
               score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
            end
            if (hit || miss) begin
               pattern_d = 4'd0;
               round_d   = round_q + 8'd1;
               state_d   = (round_q == ROUND_LAST) ? RESULT : RELEASE;
            end else if (tick) begin
               win_d = win_q - 8'd1;
            end
         end
         default: begin
            pattern_d = 4'd0;
            state_d   = IDLE;
         end
      endcase

      c_d    = (state_d != RESULT);
      res_d  = (state_d == RESULT) && ({1'b0, score_d} >= PASS9);
      busy_d = (state_d == SHOW) || (state_d == RELEASE);
   end

   // State, counters, LFSR and outputs; reset forces everything immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         score_q   <= 8'd0;
         pattern_q <= 4'd0;
         round_q   <= 8'd0;
         win_q     <= 8'd0;
         lfsr_q    <= 4'b0001;
         c_q       <= 1'b1;
         res_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         score_q   <= score_d;
         pattern_q <= pattern_d;
         round_q   <= round_d;
         win_q     <= win_d;
         lfsr_q    <= lfsr_d;
         c_q       <= c_d;
         res_q     <= res_d;
         busy_q    <= busy_d;
      end
   end

   assign score   = score_q;
   assign pattern = pattern_q;
   assign C       = c_q;
   assign res     = res_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: two instances share stimulus (POINTS=1 and
// POINTS=100) and are compared every cycle against a rule-level model.
module tb_game_sequencer;

   localparam int MR = 4;
   localparam int MW = 2;
   localparam int MP = 3;

   localparam int M_IDLE    = 0;
   localparam int M_RELEASE = 1;
   localparam int M_SHOW    = 2;
   localparam int M_RESULT  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       tick = 1'b0;
   logic [3:0] key = 4'd0;

   logic [7:0] score_a, score_b;
   logic [3:0] pattern_a, pattern_b;
   logic       c_a, c_b, res_a, res_b, busy_a, busy_b;

   int n_cmp = 0;
   int n_err = 0;

   // LFSR output sequence from the seed, one entry per clock.
   int seq [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

   int         m_mode;
   int         m_score_a, m_score_b;
   int         m_round, m_ticks, m_idx;
   logic [3:0] m_pattern;

   always #5 clk = ~clk;

   game_sequencer #(.ROUNDS(MR), .WINDOW(MW), .PASS_SCORE(MP), .POINTS(1)) dut_a (
      .clk(clk), .rst(rst), .start(start), .tick(tick), .key(key),
      .score(score_a), .pattern(pattern_a), .C(c_a), .res(res_a), .busy(busy_a));

   game_sequencer #(.ROUNDS(MR), .WINDOW(MW), .PASS_SCORE(MP), .POINTS(100)) dut_b (
      .clk(clk), .rst(rst), .start(start), .tick(tick), .key(key),
      .score(score_b), .pattern(pattern_b), .C(c_b), .res(res_b), .busy(busy_b));

   function automatic int sat_add(input int s, input int p);
      return (s + p > 255) ? 255 : s + p;
   endfunction

   task automatic model_reset();
      m_mode    = M_IDLE;
      m_score_a = 0;
      m_score_b = 0;
      m_round   = 0;
      m_ticks   = 0;
      m_idx     = 0;
      m_pattern = 4'd0;
   endtask

   task automatic model_step(input logic st, input logic tk, input logic [3:0] k);
      int  lf;
      bit  hit_m, miss_m;
      lf = seq[m_idx % 15];
      m_idx++;
      case (m_mode)
         M_IDLE, M_RESULT: begin
            if (st) begin
               m_score_a = 0;
               m_score_b = 0;
               m_round   = 0;
               m_ticks   = 0;
               m_mode    = M_RELEASE;
            end
         end
         M_RELEASE: begin
            if (k == 4'd0) begin
               m_pattern = 4'(lf);
               m_ticks   = 0;
               m_mode    = M_SHOW;
            end
         end
         default: begin
            hit_m  = (k == m_pattern);
            miss_m = (k != 4'd0 && !hit_m) || (tk && m_ticks == MW - 1);
            if (hit_m) begin
               m_score_a = sat_add(m_score_a, 1);
               m_score_b = sat_add(m_score_b, 100);
            end
            if (hit_m || miss_m) begin
               m_round++;
               m_pattern = 4'd0;
               m_mode    = (m_round == MR) ? M_RESULT : M_RELEASE;
            end else if (tk) begin
               m_ticks++;
            end
         end
      endcase
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic e_c, e_busy;
      e_c    = (m_mode != M_RESULT);
      e_busy = (m_mode == M_RELEASE) || (m_mode == M_SHOW);
      chk({tag, ".score_a"},   score_a,          8'(m_score_a));
      chk({tag, ".score_b"},   score_b,          8'(m_score_b));
      chk({tag, ".pattern_a"}, {4'd0, pattern_a}, {4'd0, m_pattern});
      chk({tag, ".pattern_b"}, {4'd0, pattern_b}, {4'd0, m_pattern});
      chk({tag, ".C_a"},       {7'd0, c_a},      {7'd0, e_c});
      chk({tag, ".C_b"},       {7'd0, c_b},      {7'd0, e_c});
      chk({tag, ".res_a"},     {7'd0, res_a},    {7'd0, (!e_c && m_score_a >= MP)});
      chk({tag, ".res_b"},     {7'd0, res_b},    {7'd0, (!e_c && m_score_b >= MP)});
      chk({tag, ".busy_a"},    {7'd0, busy_a},   {7'd0, e_busy});
      chk({tag, ".busy_b"},    {7'd0, busy_b},   {7'd0, e_busy});
   endtask

   task automatic cycle(input logic st, input logic tk, input logic [3:0] k, input string tag);
      start = st;
      tick  = tk;
      key   = k;
      @(posedge clk);
      model_step(st, tk, k);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [3:0] wrong;
      logic [3:0] rk;
      logic       rs, rt;

      // Reset at power-up, released just after an edge.
      #1 rst = 1'b0;
      model_reset();
      #1 check_all("reset");
      @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      check_all("reset_release");

      // Perfect game: hit every pattern as soon as it appears.
      cycle(1'b1, 1'b0, 4'd0, "perf_start");
      for (int r = 0; r < MR; r++) begin
         cycle(1'b0, 1'b0, 4'd0, "perf_load");
         chk("perf_pattern_nonzero", {7'd0, (pattern_a != 4'd0)}, 8'd1);
         cycle(1'b0, 1'b0, m_pattern, "perf_hit");
         chk("perf_score_step", score_a, 8'(r + 1));
      end
      chk("perf_C", {7'd0, c_a}, 8'd0);
      chk("perf_res", {7'd0, res_a}, 8'd1);
      chk("sat_score", score_b, 8'd255);
      cycle(1'b0, 1'b1, 4'd5, "result_hold");

      // Timeouts: no keys, ticks every cycle; each round ends on its second tick.
      cycle(1'b1, 1'b0, 4'd0, "to_start");
      for (int r = 0; r < MR; r++) begin
         cycle(1'b0, 1'b1, 4'd0, "to_load");
         cycle(1'b0, 1'b1, 4'd0, "to_tick1");
         chk("to_still_show", {4'd0, pattern_a}, {4'd0, m_pattern});
         cycle(1'b0, 1'b1, 4'd0, "to_tick2");
      end
      chk("to_score", score_a, 8'd0);
      chk("to_C", {7'd0, c_a}, 8'd0);
      chk("to_res", {7'd0, res_a}, 8'd0);

      // Wrong key held across the round boundary.
      cycle(1'b1, 1'b0, 4'd0, "wk_start");
      cycle(1'b0, 1'b0, 4'd0, "wk_load");
      wrong = (m_pattern == 4'hF) ? 4'h1 : ~m_pattern;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, wrong, "wk_hold");
         chk("wk_pattern_blank", {4'd0, pattern_a}, 8'd0);
         chk("wk_busy", {7'd0, busy_a}, 8'd1);
      end
      chk("wk_score", score_a, 8'd0);
      cycle(1'b0, 1'b0, 4'd0, "wk_release");
      chk("wk_new_pattern", {7'd0, (pattern_a != 4'd0)}, 8'd1);

      // Hit in the same cycle as the final-window tick.
      cycle(1'b1, 1'b1, 4'd0, "sim_tick1");
      cycle(1'b0, 1'b1, m_pattern, "sim_hit");
      chk("sim_score", score_a, 8'd1);

      // Reset mid-SHOW with a nonzero score, asserted between edges.
      cycle(1'b0, 1'b0, 4'd0, "mid_load");
      #3 rst = 1'b0;
      model_reset();
      #1 check_all("mid_reset");
      @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'd3, "idle_hold");

      // Randomised play against the model.
      for (int i = 0; i < 800; i++) begin
         rs = ($urandom_range(0, 19) == 0);
         rt = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 3))
            0, 1:    rk = 4'd0;
            2:       rk = m_pattern;
            default: rk = 4'($urandom_range(0, 15));
         endcase
         cycle(rs, rt, rk, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 16, meaning patterns per game (1..255).
REQ-002 The block SHALL have parameter WINDOW, default 8, meaning tick pulses allowed per pattern (1..255).
REQ-003 The block SHALL have parameter PASS_SCORE, default 10, meaning the minimum final score for a pass.
REQ-004 The block SHALL have parameter POINTS, default 1, meaning the score added per hit.
REQ-005 Port clk, input, 1, SHALL be the single system clock; all state updates occur on its rising edge.
REQ-006 Port rst, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-007 Port start, input, 1, SHALL be a one-cycle pulse that begins a game.
REQ-008 Port tick, input, 1, SHALL be a one-cycle timing pulse from the timing module.
REQ-009 Port key, input, 4, SHALL carry the synchronized, debounced button levels (1 = pressed).
REQ-010 Port score, output, 8, SHALL be the binary score fed to the display.
REQ-011 Port pattern, output, 4, SHALL be the target LED pattern fed to the display.
REQ-012 Port C, output, 1, SHALL be the display control: 1 = score/pattern view, 0 = verdict view.
REQ-013 Port res, output, 1, SHALL be the verdict: 1 = pass message, 0 = fail message; meaningful only when C=0.
REQ-014 Port busy, output, 1, SHALL be high in states SHOW and RELEASE.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 The FSM SHALL have states IDLE, SHOW, RELEASE and RESULT.
REQ-017 A 4-bit LFSR (x^4+x^3+1, seed 4'b0001) SHALL advance every clock, never reach zero, and be sampled whenever a pattern loads.
REQ-018 In IDLE, outputs SHALL be C=1, res=0, pattern=0 and score held; start SHALL clear score, round counter and window counter, then go to RELEASE.
REQ-019 In RELEASE, pattern SHALL be 0; when key==0, the FSM SHALL load the LFSR into pattern, clear the window counter and go to SHOW in the next cycle.
REQ-020 In SHOW, each tick SHALL increment the window counter.
REQ-021 In SHOW, a hit SHALL be key==pattern; the score SHALL then add POINTS, saturating at 255.
REQ-022 In SHOW, a miss SHALL be either key!=0 && key!=pattern, or tick arriving with window counter==WINDOW-1.
REQ-023 A hit and a miss in the same cycle SHALL count as a hit.
REQ-024 A hit or miss SHALL end the round; round counter SHALL increment; if it was ROUNDS-1, the FSM SHALL go to RESULT, otherwise to RELEASE.
REQ-025 In RESULT, outputs SHALL be C=0, res=(score>=PASS_SCORE), pattern=0 and score frozen; start SHALL begin a new game as from IDLE.
REQ-026 start SHALL be ignored in SHOW and RELEASE.
REQ-027 tick SHALL be ignored outside SHOW.
REQ-028 Only one round-ending event SHALL be processed per cycle.

Reset
REQ-029 While rst=0, the block SHALL immediately force state=IDLE, score=0, pattern=0, C=1, res=0, busy=0, counters=0, LFSR=4'b0001, regardless of the current state.
REQ-030 Operation SHALL resume on the first clk edge after rst returns high.

Verification
REQ-031 Reset: assert rst low mid-SHOW with score=5 -> without waiting for a clock edge: score=0, pattern=0, C=1, res=0, busy=0; FSM then stays in IDLE until start.
REQ-032 Perfect game: ROUNDS=4, PASS_SCORE=3; after each pattern appears, drive key=pattern, then release -> score steps 1,2,3,4; final C=0, res=1.
REQ-033 Timeouts: ROUNDS=4, WINDOW=2, key=0 throughout -> each round ends on its 2nd tick; after 8 ticks score=0, C=0, res=0.
REQ-034 Wrong key: in SHOW drive key!=pattern and hold it -> score unchanged, round counter +1, pattern=0 and busy=1 while the key is held, new nonzero pattern one cycle after key=0.
REQ-035 Simultaneous: drive key=pattern in the same cycle as the final-window tick -> score increments (hit wins).
REQ-036 Saturation: POINTS=100, three hits -> score=255, not 44.
